// File: rtl/fifo_rd_stream_pkg.sv
// Shared types for the FIFO drain stage: default word width, word type and
// the occupancy encoding of the 2-entry skid buffer.
package fifo_pkg;

  localparam int unsigned FIFO_DATA_WIDTH = 32;

  typedef logic [FIFO_DATA_WIDTH-1:0] fifo_word_t;

  // Encoding equals the number of buffered words, so the state doubles as a count.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

endpackage : fifo_pkg

// File: rtl/fifo_rd_stream_skid_buf2.sv
// Two-entry in-order queue. Entry 0 is the head and drives head_o; a capture
// appends at the tail, a pop removes the head. The head register keeps its
// last value after the queue drains so the stream data stays stable.
module skid_buf2
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cap_i,
  input  logic [DATA_WIDTH-1:0] cap_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic                  valid_o,
  output logic [1:0]            cnt_o
);

  buf_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] e0_q, e0_d;
  logic [DATA_WIDTH-1:0] e1_q, e1_d;
  logic                  pop_eff;

  // A pop only has meaning while a word is present.
  assign pop_eff = pop_i && (state_q != BUF_EMPTY);

  // Next-state and entry update for capture/pop combinations.
  always_comb begin
    state_d = state_q;
    e0_d    = e0_q;
    e1_d    = e1_q;
    unique case (state_q)
      BUF_EMPTY: begin
        if (cap_i) begin
          e0_d    = cap_data_i;
          state_d = BUF_ONE;
        end
      end
      BUF_ONE: begin
        unique case ({cap_i, pop_eff})
          2'b10: begin
            e1_d    = cap_data_i;
            state_d = BUF_TWO;
          end
          2'b01: state_d = BUF_EMPTY;
          // Head leaves and the new word takes its place in the same cycle.
          2'b11: e0_d = cap_data_i;
          default: ;
        endcase
      end
      BUF_TWO: begin
        unique case ({cap_i, pop_eff})
          2'b01: begin
            e0_d    = e1_q;
            state_d = BUF_ONE;
          end
          2'b11: begin
            e0_d = e1_q;
            e1_d = cap_data_i;
          end
          // Capture into a full queue without a pop cannot happen under the
          // credit rule upstream; the queue holds its contents if it does.
          default: ;
        endcase
      end
      default: state_d = BUF_EMPTY;
    endcase
  end

  // State and entry registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BUF_EMPTY;
      e0_q    <= '0;
      e1_q    <= '0;
    end else begin
      state_q <= state_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
    end
  end

  assign head_o  = e0_q;
  assign valid_o = (state_q != BUF_EMPTY);
  assign cnt_o   = state_q;

endmodule : skid_buf2

// File: rtl/fifo_rd_stream.sv
// Drain stage for the 8x32 FIFO: issues pops against a two-word credit,
// captures the registered FIFO read data one cycle later into a skid buffer
// and presents it on a valid/ready stream with a delivered-word counter.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  out_count
);

  logic                 inflight_q;
  logic [1:0]           buf_cnt;
  logic [1:0]           occ;
  logic                 pop;
  logic [CNT_WIDTH-1:0] out_count_q, out_count_d;

  assign pop = out_valid && out_ready;
  assign occ = buf_cnt + {1'b0, inflight_q};

  // Credit check: a pop is issued only if its word is guaranteed a slot when
  // it arrives next cycle, counting the word already in flight.
  always_comb begin
    fifo_rd_en = 1'b0;
    if (!reset && !fifo_empty) begin
      fifo_rd_en = (occ < 2'd2) || ((occ == 2'd2) && pop);
    end
  end

  // Delivered-word counter, wraps naturally at its width.
  always_comb begin
    out_count_d = out_count_q;
    if (pop) begin
      out_count_d = out_count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // In-flight flag and counter; reset discards a word still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_q  <= 1'b0;
      out_count_q <= '0;
    end else begin
      inflight_q  <= fifo_rd_en;
      out_count_q <= out_count_d;
    end
  end

  skid_buf2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk        (clk),
    .reset      (reset),
    .cap_i      (inflight_q),
    .cap_data_i (fifo_data),
    .pop_i      (pop),
    .head_o     (out_data),
    .valid_o    (out_valid),
    .cnt_o      (buf_cnt)
  );

  assign out_count = out_count_q;

endmodule : fifo_rd_stream

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural registered-read FIFO.
module tb_fifo_rd_stream;
  import fifo_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        fifo_empty;
  logic        fifo_rd_en;
  fifo_word_t  fifo_data = '0;
  logic        out_valid;
  logic        out_ready;
  fifo_word_t  out_data;
  logic [15:0] out_count;

  // Second instance with a 4-bit counter fed by an always-non-empty source.
  logic        rst4;
  logic        empty4;
  logic        rd_en4;
  fifo_word_t  data4 = '0;
  fifo_word_t  src4 = 32'h100;
  logic        valid4;
  logic        ready4;
  fifo_word_t  out_data4;
  logic [3:0]  count4;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  // Behavioural FIFO: written by the stimulus, read with one-cycle latency.
  fifo_word_t  fmem [0:63];
  int unsigned fwr = 0;
  int unsigned frd = 0;
  assign fifo_empty = (frd == fwr);

  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_data <= fmem[frd];
      frd       <= frd + 1;
    end
  end

  always @(posedge clk) begin
    if (rd_en4) begin
      data4 <= src4;
      src4  <= src4 + 1;
    end
  end

  fifo_rd_stream dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_data  (fifo_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_count  (out_count)
  );

  fifo_rd_stream #(
    .DATA_WIDTH (32),
    .CNT_WIDTH  (4)
  ) dut4 (
    .clk        (clk),
    .reset      (rst4),
    .fifo_empty (empty4),
    .fifo_rd_en (rd_en4),
    .fifo_data  (data4),
    .out_valid  (valid4),
    .out_ready  (ready4),
    .out_data   (out_data4),
    .out_count  (count4)
  );

  // Structural invariants checked every cycle: no capture into a full buffer
  // without a pop, no pop request against an empty FIFO, occupancy <= 2.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      vectors++;
      if (dut.inflight_q && dut.u_buf.cnt_o == 2'd2 && !(out_valid && out_ready)) begin
        miscompares++;
        $display("FAIL invariant_overflow: capture with buf_cnt=2 and no pop at %0t", $time);
      end
      vectors++;
      if (fifo_rd_en && fifo_empty) begin
        miscompares++;
        $display("FAIL rd_en_when_empty: fifo_rd_en=1 with fifo_empty=1 at %0t", $time);
      end
      vectors++;
      if (dut.u_buf.cnt_o > 2'd2) begin
        miscompares++;
        $display("FAIL buf_cnt_range: got %0d required <=2", dut.u_buf.cnt_o);
      end
    end
  end

  task automatic push(input fifo_word_t w);
    fmem[fwr] = w;
    fwr = fwr + 1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    out_ready = 1'b0;
    push(32'hA5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      vectors++;
      if (fifo_rd_en !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_rd_en[%0d]: got %b required 0", i, fifo_rd_en);
      end
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_valid[%0d]: got %b required 0", i, out_valid);
      end
      vectors++;
      if (out_count !== 16'd0) begin
        miscompares++;
        $display("FAIL reset_count[%0d]: got %0d required 0", i, out_count);
      end
      vectors++;
      if (out_data !== 32'd0) begin
        miscompares++;
        $display("FAIL reset_data[%0d]: got %h required 0", i, out_data);
      end
    end
    // Release: rd_en at once, out_valid two edges later.
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    #1;
    vectors++;
    if (fifo_rd_en !== 1'b1) begin
      miscompares++;
      $display("FAIL latency_rd_en: got %b required 1", fifo_rd_en);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_valid_e1: got %b required 0", out_valid);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 32'hA5) begin
      miscompares++;
      $display("FAIL latency_valid_e2: got valid=%b data=%h required 1/a5", out_valid, out_data);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (out_count !== 16'd1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_count: got count=%0d valid=%b required 1/0", out_count, out_valid);
    end
  endtask

  task automatic test_streaming();
    pulse_reset();
    out_ready = 1'b1;
    for (int unsigned w = 1; w <= 8; w++) push(w);
    for (int i = 0; i < 11; i++) begin
      #1;
      vectors++;
      if (fifo_rd_en !== (i < 8)) begin
        miscompares++;
        $display("FAIL stream_rd_en[%0d]: got %b required %b", i, fifo_rd_en, (i < 8));
      end
      vectors++;
      if (out_valid !== (i >= 2 && i <= 9)) begin
        miscompares++;
        $display("FAIL stream_valid[%0d]: got %b required %b", i, out_valid, (i >= 2 && i <= 9));
      end
      if (i >= 2 && i <= 9) begin
        vectors++;
        if (out_data !== 32'(i - 1)) begin
          miscompares++;
          $display("FAIL stream_data[%0d]: got %h required %h", i, out_data, 32'(i - 1));
        end
      end
      @(negedge clk);
    end
    #1;
    vectors++;
    if (out_count !== 16'd8) begin
      miscompares++;
      $display("FAIL stream_count: got %0d required 8", out_count);
    end
  endtask

  task automatic test_backpressure();
    int unsigned frd0;
    int unsigned got;
    fifo_word_t  seen [4];
    pulse_reset();
    out_ready = 1'b0;
    frd0 = frd;
    for (int unsigned w = 0; w < 4; w++) push(32'h10 + w);
    for (int i = 0; i < 6; i++) begin
      #1;
      vectors++;
      if (fifo_rd_en !== (i < 2)) begin
        miscompares++;
        $display("FAIL bp_rd_en[%0d]: got %b required %b", i, fifo_rd_en, (i < 2));
      end
      if (i >= 2) begin
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'h10) begin
          miscompares++;
          $display("FAIL bp_hold[%0d]: got valid=%b data=%h required 1/10", i, out_valid, out_data);
        end
      end
      @(negedge clk);
    end
    vectors++;
    if (frd - frd0 != 2) begin
      miscompares++;
      $display("FAIL bp_pops: got %0d required 2", frd - frd0);
    end
    vectors++;
    if (dut.u_buf.cnt_o !== 2'd2) begin
      miscompares++;
      $display("FAIL bp_buf_cnt: got %0d required 2", dut.u_buf.cnt_o);
    end
    out_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && got < 5; i++) begin
      #1;
      if (out_valid && out_ready) begin
        if (got < 4) seen[got] = out_data;
        got++;
      end
      @(negedge clk);
    end
    vectors++;
    if (got != 4) begin
      miscompares++;
      $display("FAIL bp_word_count: got %0d required 4", got);
    end
    for (int unsigned k = 0; k < 4; k++) begin
      vectors++;
      if (k < got && seen[k] !== 32'h10 + k) begin
        miscompares++;
        $display("FAIL bp_order[%0d]: got %h required %h", k, seen[k], 32'h10 + k);
      end
    end
    vectors++;
    if (out_count !== 16'd4) begin
      miscompares++;
      $display("FAIL bp_count: got %0d required 4", out_count);
    end
  endtask

  task automatic test_toggle();
    int unsigned got;
    pulse_reset();
    for (int unsigned w = 0; w < 8; w++) push(32'h20 + w);
    got = 0;
    for (int i = 0; i < 40 && got < 8; i++) begin
      out_ready = (i % 2 == 0);
      #1;
      if (out_valid && out_ready) begin
        vectors++;
        if (out_data !== 32'h20 + got) begin
          miscompares++;
          $display("FAIL toggle_order[%0d]: got %h required %h", got, out_data, 32'h20 + got);
        end
        got++;
      end
      @(negedge clk);
    end
    vectors++;
    if (got != 8) begin
      miscompares++;
      $display("FAIL toggle_timeout: got %0d words required 8", got);
    end
    #1;
    vectors++;
    if (out_count !== 16'd8) begin
      miscompares++;
      $display("FAIL toggle_count: got %0d required 8", out_count);
    end
  endtask

  task automatic test_reset_midflight();
    int unsigned frd0;
    out_ready = 1'b1;
    frd0 = frd;
    push(32'h55);
    #1;
    vectors++;
    if (fifo_rd_en !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_rd_en: got %b required 1", fifo_rd_en);
    end
    @(negedge clk);
    vectors++;
    if (dut.inflight_q !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_inflight: got %b required 1", dut.inflight_q);
    end
    reset = 1'b1;
    @(negedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_count !== 16'd0 || out_data !== 32'd0) begin
      miscompares++;
      $display("FAIL mid_after_reset: got valid=%b count=%0d data=%h required 0/0/0",
               out_valid, out_count, out_data);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      vectors++;
      if (out_valid !== 1'b0 || out_count !== 16'd0) begin
        miscompares++;
        $display("FAIL mid_discard[%0d]: got valid=%b count=%0d required 0/0", i, out_valid, out_count);
      end
    end
    vectors++;
    if (frd - frd0 != 1) begin
      miscompares++;
      $display("FAIL mid_fifo_pop: got %0d required 1", frd - frd0);
    end
  endtask

  task automatic test_wrap();
    int unsigned npop;
    npop = 0;
    @(negedge clk);
    rst4   = 1'b0;
    ready4 = 1'b1;
    for (int i = 0; i < 40 && npop < 17; i++) begin
      #1;
      vectors++;
      if (count4 !== 4'(npop)) begin
        miscompares++;
        $display("FAIL wrap_count[%0d]: got %0d required %0d", i, count4, 4'(npop));
      end
      if (valid4) begin
        vectors++;
        if (out_data4 !== 32'h100 + npop) begin
          miscompares++;
          $display("FAIL wrap_data[%0d]: got %h required %h", npop, out_data4, 32'h100 + npop);
        end
        npop++;
      end
      @(negedge clk);
    end
    ready4 = 1'b0;
    #1;
    vectors++;
    if (npop != 17 || count4 !== 4'd1) begin
      miscompares++;
      $display("FAIL wrap_final: got pops=%0d count=%0d required 17/1", npop, count4);
    end
  endtask

  initial begin
    reset  = 1'b1;
    rst4   = 1'b1;
    empty4 = 1'b0;
    ready4 = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_toggle();
    test_reset_midflight();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_fifo_rd_stream
